// File: rtl/result_fifo_pkg.sv
// Shared parameters and helpers for the result FIFO reader.
// Holds the DEPTH legality check and the occupancy width derivation.
package result_fifo_pkg;

    localparam int RESULT_WIDTH_DEF = 32;

    function automatic bit depth_ok(input int d);
        return (d >= 2) && (d <= 1024) && ((d & (d - 1)) == 0);
    endfunction

    function automatic int count_width(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/result_ring_buffer.sv
// Circular buffer with first-word-fall-through head read.
// Callers only present push/pop when they are legal for the current occupancy.
module result_ring_buffer
    import result_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = RESULT_WIDTH_DEF,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset so it can map to distributed RAM.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/result_fifo_reader.sv
// Captures sequencer result words on WrReq rising edges and serves them
// to the bus as a valid/ready read port with occupancy and overflow status.
module result_fifo_reader
    import result_fifo_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int RESULT_WIDTH   = RESULT_WIDTH_DEF,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int COUNT_WIDTH    = count_width(DEPTH)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [RESULT_WIDTH-1:0]   rFIFO_data,
    input  logic                      rFIFO_WrReq,
    input  logic                      init,
    output logic [BUS_DATA_WIDTH-1:0] bus_rd_data,
    output logic                      bus_rd_valid,
    input  logic                      bus_rd_ready,
    output logic [COUNT_WIDTH-1:0]    count,
    output logic                      full,
    output logic                      overflow,
    input  logic                      clear_overflow,
    output logic [31:0]               words_total
);

    generate
        if (!depth_ok(DEPTH)) begin : g_bad_depth
            $error("result_fifo_reader: DEPTH must be a power of two in 2..1024");
        end
        if (BUS_DATA_WIDTH != RESULT_WIDTH) begin : g_bad_width
            $error("result_fifo_reader: BUS_DATA_WIDTH must equal RESULT_WIDTH");
        end
    endgenerate

    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

    logic wrreq_d;
    logic push_req;
    logic pop;
    logic push;
    logic drop;
    logic [RESULT_WIDTH-1:0] head_data;

    assign push_req     = rFIFO_WrReq & ~wrreq_d;
    assign bus_rd_valid = (count != '0);
    assign full         = (count == FULL_COUNT);
    assign pop          = bus_rd_valid & bus_rd_ready;
    // A pop frees the slot in the same cycle, so a full buffer still accepts.
    assign push         = push_req & (~full | pop);
    assign drop         = push_req & full & ~pop;
    assign bus_rd_data  = head_data;

    result_ring_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (RESULT_WIDTH),
        .CW    (COUNT_WIDTH)
    ) u_ring (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (init),
        .push      (push),
        .push_data (rFIFO_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wrreq_d     <= 1'b0;
            overflow    <= 1'b0;
            words_total <= '0;
        end else begin
            wrreq_d <= rFIFO_WrReq;
            if (init) begin
                overflow    <= 1'b0;
                words_total <= '0;
            end else begin
                if (drop)                overflow <= 1'b1;
                else if (clear_overflow) overflow <= 1'b0;
                if (push) words_total <= words_total + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_result_fifo_reader.sv
// Directed bench for result_fifo_reader with DEPTH = 16.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_result_fifo_reader;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] rFIFO_data;
    logic        rFIFO_WrReq;
    logic        init;
    logic [31:0] bus_rd_data;
    logic        bus_rd_valid;
    logic        bus_rd_ready;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
    logic        clear_overflow;
    logic [31:0] words_total;

    int checks = 0;
    int errors = 0;

    result_fifo_reader #(
        .DEPTH          (16),
        .RESULT_WIDTH   (32),
        .BUS_DATA_WIDTH (32)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .rFIFO_data     (rFIFO_data),
        .rFIFO_WrReq    (rFIFO_WrReq),
        .init           (init),
        .bus_rd_data    (bus_rd_data),
        .bus_rd_valid   (bus_rd_valid),
        .bus_rd_ready   (bus_rd_ready),
        .count          (count),
        .full           (full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .words_total    (words_total)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        rFIFO_data  = d;
        rFIFO_WrReq = 1'b1;
        tick();
        rFIFO_WrReq = 1'b0;
        tick();
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    initial begin
        resetn         = 1'b0;
        rFIFO_data     = '0;
        rFIFO_WrReq    = 1'b0;
        init           = 1'b0;
        bus_rd_ready   = 1'b0;
        clear_overflow = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();

        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(bus_rd_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_total", words_total, 32'd0);

        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        chk("three_count", 32'(count), 32'd3);
        chk("three_valid", 32'(bus_rd_valid), 32'd1);
        bus_rd_ready = 1'b1;
        chk("rd0", bus_rd_data, 32'h11);
        tick();
        chk("rd1", bus_rd_data, 32'h22);
        tick();
        chk("rd2", bus_rd_data, 32'h33);
        tick();
        chk("drain_valid", 32'(bus_rd_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("three_total", words_total, 32'd3);
        bus_rd_ready = 1'b0;

        do_init();
        chk("init_total", words_total, 32'd0);
        rFIFO_data  = 32'hABCD;
        rFIFO_WrReq = 1'b1;
        repeat (10) tick();
        rFIFO_WrReq = 1'b0;
        tick();
        chk("hold_count", 32'(count), 32'd1);
        chk("hold_total", words_total, 32'd1);
        chk("hold_data", bus_rd_data, 32'hABCD);
        bus_rd_ready = 1'b1;
        tick();
        bus_rd_ready = 1'b0;
        chk("hold_drain", 32'(count), 32'd0);

        do_init();
        for (int i = 0; i < 16; i++) push_word(32'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf0", 32'(overflow), 32'd0);
        push_word(32'd16);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_total", words_total, 32'd16);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);

        chk("full_head", bus_rd_data, 32'd0);
        rFIFO_data   = 32'h99;
        rFIFO_WrReq  = 1'b1;
        bus_rd_ready = 1'b1;
        tick();
        rFIFO_WrReq  = 1'b0;
        bus_rd_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_total", words_total, 32'd17);
        tick();
        bus_rd_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("seq%0d", i), bus_rd_data, 32'(i));
            tick();
        end
        chk("last_99", bus_rd_data, 32'h99);
        tick();
        chk("empty_valid", 32'(bus_rd_valid), 32'd0);
        bus_rd_ready = 1'b0;

        do_init();
        for (int i = 0; i < 17; i++) push_word(32'(i + 100));
        bus_rd_ready = 1'b1;
        repeat (11) tick();
        bus_rd_ready = 1'b0;
        chk("five_count", 32'(count), 32'd5);
        chk("five_ovf", 32'(overflow), 32'd1);
        rFIFO_data  = 32'h55;
        rFIFO_WrReq = 1'b1;
        init        = 1'b1;
        tick();
        init = 1'b0;
        chk("ip_count", 32'(count), 32'd0);
        chk("ip_valid", 32'(bus_rd_valid), 32'd0);
        chk("ip_ovf", 32'(overflow), 32'd0);
        chk("ip_total", words_total, 32'd0);
        rFIFO_WrReq = 1'b0;
        tick();
        chk("ip_after", 32'(count), 32'd0);

        for (int i = 0; i < 17; i++) push_word(32'(i + 200));
        chk("co_pre", 32'(overflow), 32'd1);
        rFIFO_data     = 32'h77;
        rFIFO_WrReq    = 1'b1;
        clear_overflow = 1'b1;
        tick();
        rFIFO_WrReq    = 1'b0;
        clear_overflow = 1'b0;
        chk("co_prio", 32'(overflow), 32'd1);
        tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("co_alone", 32'(overflow), 32'd0);
        chk("co_total", words_total, 32'd16);

        #3;
        resetn = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(bus_rd_valid), 32'd0);
        chk("arst_total", words_total, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
